// File: rtl/mips_mcycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder and PC-enable logic.
// Optional build macro MCYCLE_BNE_EN adds the BNE state for opcode 000101.
module mips_mcycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11,
        BNE = 4'd12
    } state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCYCLE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    state_t state_q, state_d;
    aluop_t aluop;
    logic   memwrite_s, irwrite_s, regwrite_s, pcen_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        aluop      = ALU_ADD;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        pcen_s     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                irwrite_s = 1'b1;
                pcen_s    = 1'b1;
                alusrcb   = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
`ifdef MCYCLE_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR, ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (state_q == ADDIEXEC) state_d = ADDIWB;
                else if (op == OP_LW)    state_d = MEMRD;
                else if (op == OP_SW)    state_d = MEMWR;
                else                     state_d = FETCH;
            end
            MEMRD: begin
                state_d = MEMWB;
                iord    = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            EXECUTE: begin
                state_d = ALUWB;
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            ADDIWB: regwrite_s = 1'b1;
            BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                aluop   = ALU_SUB;
                pcen_s  = zero;
            end
`ifdef MCYCLE_BNE_EN
            BNE: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                aluop   = ALU_SUB;
                pcen_s  = ~zero;
            end
`endif
            JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Write enables are forced low for the whole time reset is held.
    assign memwrite = memwrite_s & ~reset;
    assign irwrite  = irwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcen     = pcen_s & ~reset;
    assign state    = state_q;
endmodule

// File: doc/mips_mcycle_ctrl.md
MIPS_MCYCLE_CTRL -- requirements
Module: mips_mcycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port op, input, 6 bits: instruction opcode field [31:26].
REQ-004 SHALL have port funct, input, 6 bits: instruction funct field [5:0].
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag for the current cycle's ALU result.
REQ-006 SHALL have port alucontrol, output, 3 bits: ALU op select (000 AND, 001 OR, 010 add, 110 sub, 111 slt).
REQ-007 SHALL have ports memwrite, irwrite, regwrite, pcen, output, 1 bit each: write enables.
REQ-008 SHALL have ports iord, memtoreg, regdst, alusrca, output, 1 bit each: datapath mux selects.
REQ-009 SHALL have ports alusrcb, pcsrc, output, 2 bits each: datapath mux selects.
REQ-010 SHALL have port state, output, 4 bits: current FSM state code, for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, BNE=12.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE by op:
- 100011/101011 -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEXEC
- 000010 -> JUMP
- any other op -> FETCH, with no write enable asserted
REQ-014 SHALL transition as follows:
- MEMADR -> MEMRD (op 100011) or MEMWR (op 101011)
- MEMRD -> MEMWB
- EXECUTE -> ALUWB
- ADDIEXEC -> ADDIWB
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, BNE, JUMP -> FETCH
REQ-015 SHALL drive the following per state; any signal not listed is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=add
- DECODE: alusrcb=11, aluop=add
- MEMADR, ADDIEXEC: alusrca=1, alusrcb=10, aluop=add
- MEMRD: iord=1
- MEMWR: iord=1, memwrite=1
- MEMWB: memtoreg=1, regwrite=1
- EXECUTE: alusrca=1, aluop=funct
- ALUWB: regdst=1, regwrite=1
- ADDIWB: regwrite=1
- BRANCH/BNE: alusrca=1, pcsrc=01, aluop=sub
- JUMP: pcsrc=10, pcwrite=1
REQ-016 SHALL set alucontrol=010 for aluop=add and 110 for aluop=sub.
REQ-017 SHALL map funct for aluop=funct as follows: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->010.
REQ-018 SHALL compute pcen = pcwrite | (state==BRANCH & zero) | (state==BNE & ~zero), combinationally from the same-cycle zero.
REQ-019 SHALL give instruction latencies in cycles from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, unknown 2.
REQ-020 SHALL return to FETCH on the next clock edge from any unused state code (13-15), with all write enables 0 while in that state.
REQ-021 SHALL sample op only in DECODE and MEMADR; op changes in other states SHALL NOT alter the sequence.

Reset
REQ-022 SHALL force state to FETCH asynchronously when reset rises, independent of clk.
REQ-023 SHALL hold memwrite, irwrite, regwrite and pcen at 0 while reset is high; all other outputs SHALL show FETCH values.
REQ-024 SHALL abandon any in-flight instruction on reset assertion, including mid-MEMWR and mid-BRANCH, with no further write issued.
REQ-025 SHALL enter DECODE on the first rising clk edge after reset deasserts.

Configuration
REQ-026 SHALL support macro MCYCLE_BNE_EN: when defined, DECODE with op 000101 SHALL go to BNE; when undefined, op 000101 SHALL be treated as unknown per REQ-013 and state code 12 as unused per REQ-020.

Verification
REQ-027 SHALL cover reset mid-MEMWR: assert reset in MEMWR -> memwrite=0 immediately, state=0; after release, state sequence 0,1.
REQ-028 SHALL cover lw (op=100011): state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-029 SHALL cover R-type slt (op=000000, funct=101010): alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB.
REQ-030 SHALL cover beq (op=000100) with zero=1 then zero=0: pcen=1, pcsrc=01 in BRANCH for zero=1; pcen=0 for zero=0.
REQ-031 SHALL cover bne (op=000101) with zero=0: with MCYCLE_BNE_EN, state 12 and pcen=1; without it, DECODE->FETCH and pcen=0.
REQ-032 SHALL cover unknown op 111111: sequence 0,1,0, with memwrite, regwrite, irwrite and pcen all 0 in DECODE.
